// File: rtl/fetch_unit_if.sv
// Fetch stage bus: control inputs from hazard/execute, async imem port,
// and the decoded slot presented to the fetch/decode pipeline register.
interface fetch_unit_if #(
   parameter int ADDR_W = 32
);
   logic              stall;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic              int_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_data;
   logic [4:0]        opcode;
   logic [2:0]        rs;
   logic [2:0]        rd;
   logic [4:0]        shmnt;
   logic [ADDR_W-1:0] pc_out;
   logic [ADDR_W-1:0] next_inst_addr;
   logic              int1;
   logic              int2;
   logic              valid;

   modport master (
      input  stall, branch_taken, branch_target, int_req, imem_data,
      output imem_addr, opcode, rs, rd, shmnt, pc_out, next_inst_addr,
             int1, int2, valid
   );

   modport slave (
      output stall, branch_taken, branch_target, int_req, imem_data,
      input  imem_addr, opcode, rs, rd, shmnt, pc_out, next_inst_addr,
             int1, int2, valid
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, loads reset/interrupt vectors as two 16-bit
// halves, and presents one decoded slot per cycle (combinational from state).
module fetch_unit #(
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RST_VEC_ADDR = ADDR_W'(0),
   parameter logic [ADDR_W-1:0] INT_VEC_ADDR = ADDR_W'(2),
   parameter logic [4:0]        NOP_OPCODE   = 5'b00000
) (
   input  logic        clk,
   input  logic        rst_n,
   fetch_unit_if.master bus
);
   typedef enum logic [1:0] {RST_LO, RST_HI, RUN, INT2} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [15:0]       vec_lo;
   logic              int_pend;

   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] vec_pc;
   logic              int_clr;

   assign pc_inc  = pc + ADDR_W'(1);
   assign vec_pc  = ADDR_W'({bus.imem_data, vec_lo});
   assign int_clr = (state == RUN) && !bus.branch_taken && !bus.stall && int_pend;

   always_comb begin
      bus.imem_addr      = RST_VEC_ADDR;
      bus.opcode         = NOP_OPCODE;
      bus.rs             = 3'd0;
      bus.rd             = 3'd0;
      bus.shmnt          = 5'd0;
      bus.pc_out         = '0;
      bus.next_inst_addr = '0;
      bus.int1           = 1'b0;
      bus.int2           = 1'b0;
      bus.valid          = 1'b0;
      case (state)
         RST_LO: bus.imem_addr = RST_VEC_ADDR;
         RST_HI: bus.imem_addr = RST_VEC_ADDR + ADDR_W'(1);
         RUN: begin
            if (bus.branch_taken) begin
               bus.imem_addr = pc;
            end else if (!bus.stall && int_pend) begin
               bus.imem_addr = INT_VEC_ADDR;
               bus.pc_out    = pc;
               bus.int1      = 1'b1;
               bus.valid     = 1'b1;
            end else begin
               // a stalled slot still shows the instruction at pc
               bus.imem_addr      = pc;
               bus.opcode         = bus.imem_data[15:11];
               bus.rs             = bus.imem_data[10:8];
               bus.rd             = bus.imem_data[7:5];
               bus.shmnt          = bus.imem_data[4:0];
               bus.pc_out         = pc;
               bus.next_inst_addr = pc_inc;
               bus.valid          = 1'b1;
            end
         end
         INT2: begin
            bus.imem_addr = INT_VEC_ADDR + ADDR_W'(1);
            // an older branch resolving here corrects the saved return address
            bus.pc_out    = bus.branch_taken ? bus.branch_target : pc;
            bus.int2      = 1'b1;
            bus.valid     = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RST_LO;
         pc       <= '0;
         vec_lo   <= '0;
         int_pend <= 1'b0;
      end else begin
         // a new request in the clearing cycle wins, so it stays queued
         int_pend <= bus.int_req | (int_pend & ~int_clr);
         case (state)
            RST_LO: begin
               vec_lo <= bus.imem_data;
               state  <= RST_HI;
            end
            RST_HI: begin
               pc    <= vec_pc;
               state <= RUN;
            end
            RUN: begin
               if (bus.branch_taken) begin
                  pc <= bus.branch_target;
               end else if (bus.stall) begin
                  pc <= pc;
               end else if (int_pend) begin
                  vec_lo <= bus.imem_data;
                  state  <= INT2;
               end else begin
                  pc <= pc_inc;
               end
            end
            INT2: begin
               if (!bus.stall) begin
                  pc    <= vec_pc;
                  state <= RUN;
               end
            end
            default: state <= RST_LO;
         endcase
      end
   end
endmodule
